// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default widths for the two-port memory bus arbiter.
package mem_bus_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef logic port_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin winner select with a bounded lock extension.
module rr_pick
    import mem_bus_pkg::*;
#(
    parameter int MAX_LOCK = 4,
    parameter int CNT_W    = $clog2(MAX_LOCK + 1)
) (
    input  logic [1:0]       req,
    input  logic [1:0]       lock,
    input  port_t            last_grant,
    input  logic [CNT_W-1:0] lock_count,
    output logic             any,
    output port_t            winner,
    output logic [CNT_W-1:0] next_count
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LOCK);

    logic hold;

    always_comb begin
        any  = |req;
        hold = lock[last_grant] && (lock_count < MAX_C);
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end else if (hold) begin
            winner = last_grant;
        end else begin
            winner = ~last_grant;
        end

        // Only a repeat grant to a port still asking for lock keeps counting.
        if ((winner == last_grant) && lock[winner]) begin
            next_count = (lock_count == MAX_C) ? MAX_C : lock_count + 1'b1;
        end else begin
            next_count = '0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter issuing one registered memory access at a time.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_LATENCY = 1,
    parameter int MAX_LOCK    = 4
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              req0,
    input  logic              lock0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              valid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              lock1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              valid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              memEnable,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [1:0] LAST_WAIT = 2'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic [1:0]        wait_q, wait_d;
    port_t             owner_q, owner_d;
    port_t             last_q, last_d;
    logic [CNT_W-1:0]  lcnt_q, lcnt_d;
    logic              op_wr_q, op_wr_d;
    logic              en_q, en_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        valid_q, valid_d;
    logic [DATA_W-1:0] rd0_q, rd0_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;

    logic              any;
    port_t             winner;
    logic [CNT_W-1:0]  next_count;

    rr_pick #(
        .MAX_LOCK (MAX_LOCK),
        .CNT_W    (CNT_W)
    ) u_pick (
        .req        ({req1, req0}),
        .lock       ({lock1, lock0}),
        .last_grant (last_q),
        .lock_count (lcnt_q),
        .any        (any),
        .winner     (winner),
        .next_count (next_count)
    );

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q <= IDLE;
            wait_q  <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            lcnt_q  <= '0;
            op_wr_q <= 1'b0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= '0;
            valid_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            lcnt_q  <= lcnt_d;
            op_wr_q <= op_wr_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        owner_d = owner_q;
        last_d  = last_q;
        lcnt_d  = lcnt_q;
        op_wr_d = op_wr_q;
        en_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        gnt_d   = '0;
        valid_d = '0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;

        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d        = ISSUE;
                    owner_d        = winner;
                    last_d         = winner;
                    lcnt_d         = next_count;
                    op_wr_d        = winner ? we1 : we0;
                    en_d           = 1'b1;
                    wr_d           = winner ? we1 : we0;
                    addr_d         = winner ? addr1 : addr0;
                    wdata_d        = winner ? wdata1 : wdata0;
                    gnt_d[winner]  = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wait_d  = '0;
            end
            WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    state_d          = IDLE;
                    valid_d[owner_q] = 1'b1;
                    // Writes leave the port's read data untouched.
                    if (!op_wr_q) begin
                        if (owner_q) rd1_d = memRdata;
                        else         rd0_d = memRdata;
                    end
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt0      = gnt_q[0];
    assign gnt1      = gnt_q[1];
    assign valid0    = valid_q[0];
    assign valid1    = valid_q[1];
    assign rdata0    = rd0_q;
    assign rdata1    = rd1_q;
    assign memEnable = en_q;
    assign memWrite  = wr_q;
    assign memAddr   = addr_q;
    assign memWdata  = wdata_q;

endmodule
